gnr_attractor_ctrl: RTL and testbench

- Run controller and result collector for the GNR node array.
- For each initial state it drives the per-node load and step strobes (reset_nos, start_s0, start_s1), compares the tortoise state vector (all icos_s0) with the hare state vector (all icos_s1), and measures the attractor period.
- Each result leaves on a valid/ready stream to the host-facing FIFO.

---
 rtl/gnr_pkg.sv | 17 +
 rtl/gnr_result_reg.sv | 28 ++
 rtl/gnr_attractor_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_gnr_attractor_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gnr_pkg.sv
// Shared constants and FSM state encoding for the GNR attractor run controller.
package gnr_pkg;

    localparam int GNR_N_NODES = 188;
    localparam int GNR_CNT_W   = 32;

    typedef logic [2:0] gnr_state_t;

    localparam gnr_state_t ST_IDLE   = 3'd0;
    localparam gnr_state_t ST_LOAD   = 3'd1;
    localparam gnr_state_t ST_STEP   = 3'd2;
    localparam gnr_state_t ST_CHECK  = 3'd3;
    localparam gnr_state_t ST_PSTEP  = 3'd4;
    localparam gnr_state_t ST_PCHECK = 3'd5;
    localparam gnr_state_t ST_REPORT = 3'd6;

endpackage

// File: rtl/gnr_result_reg.sv
// Single-entry valid/ready holding register for one result record.
// Handshake: data moves on a cycle where valid && ready; valid stays high and data
// stays frozen until then. ld is only issued while the register is empty.
module gnr_result_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] ld_data,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (ld) begin
            valid <= 1'b1;
            data  <= ld_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Run controller: loads each initial state, runs tortoise/hare to a meet, measures the period.
// Optional macro GNR_ATTRACTOR_STATE_EN adds res_state (hare vector latched at the meet).
module gnr_attractor_ctrl
    import gnr_pkg::*;
#(
    parameter int N_NODES = GNR_N_NODES,
    parameter int CNT_W   = GNR_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_base,
    input  logic [CNT_W-1:0]   num_states,
    input  logic [CNT_W-1:0]   max_steps,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [N_NODES-1:0] init_vec,
    input  logic [N_NODES-1:0] tort_vec,
    input  logic [N_NODES-1:0] hare_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   res_idx,
    output logic [CNT_W-1:0]   res_steps,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout,
`ifdef GNR_ATTRACTOR_STATE_EN
    output logic [N_NODES-1:0] res_state,
`endif
    output logic               busy,
    output logic               done,
    output logic [2:0]         dbg_state
);

    typedef struct packed {
        logic [CNT_W-1:0]   idx;
        logic [CNT_W-1:0]   steps;
        logic [CNT_W-1:0]   period;
        logic               timeout;
`ifdef GNR_ATTRACTOR_STATE_EN
        logic [N_NODES-1:0] state;
`endif
    } res_rec_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    gnr_state_t         state;
    logic [CNT_W-1:0]   idx, idx_nxt, n_states, max_st;
    logic [CNT_W-1:0]   step_cnt, per_cnt, steps_q;
    logic [N_NODES-1:0] base;
`ifdef GNR_ATTRACTOR_STATE_EN
    logic [N_NODES-1:0] meet_state;
`endif
    logic               vec_eq, meet, chk_to, per_to, fire, ld_en;
    res_rec_t           ld_rec, out_rec;

    // A meet at step 1 is only the shared initial state, so it is skipped.
    assign vec_eq  = (tort_vec == hare_vec);
    assign meet    = (step_cnt >= CNT_W'(2)) && vec_eq;
    assign chk_to  = (max_st != '0) && (step_cnt == max_st);
    assign per_to  = (max_st != '0) && (per_cnt == max_st);
    assign fire    = (state == ST_REPORT) && res_valid && res_ready;
    assign idx_nxt = sat_inc(idx);

    // Strobes decode straight from state, so REPORT (and any stall in it) drives none.
    assign reset_nos = (state == ST_LOAD);
    assign start_s0  = (state == ST_STEP);
    assign start_s1  = (state == ST_STEP) || (state == ST_PSTEP);
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_comb begin
        ld_en      = 1'b0;
        ld_rec     = '0;
        ld_rec.idx = idx;
        case (state)
            ST_CHECK: begin
                if (!meet && chk_to) begin
                    ld_en          = 1'b1;
                    ld_rec.steps   = step_cnt;
                    ld_rec.timeout = 1'b1;
                end
            end
            ST_PCHECK: begin
                if (vec_eq) begin
                    ld_en         = 1'b1;
                    ld_rec.steps  = steps_q;
                    ld_rec.period = per_cnt;
`ifdef GNR_ATTRACTOR_STATE_EN
                    ld_rec.state  = meet_state;
`endif
                end else if (per_to) begin
                    ld_en          = 1'b1;
                    ld_rec.steps   = steps_q;
                    ld_rec.timeout = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            n_states   <= '0;
            max_st     <= '0;
            base       <= '0;
            init_vec   <= '0;
            step_cnt   <= '0;
            per_cnt    <= '0;
            steps_q    <= '0;
            done       <= 1'b0;
`ifdef GNR_ATTRACTOR_STATE_EN
            meet_state <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_states <= num_states;
                        max_st   <= max_steps;
                        base     <= init_base;
                        idx      <= '0;
                        if (num_states == '0) begin
                            done <= 1'b1;
                        end else begin
                            init_vec <= init_base;
                            state    <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    step_cnt <= '0;
                    per_cnt  <= '0;
                    state    <= ST_STEP;
                end
                ST_STEP: begin
                    step_cnt <= sat_inc(step_cnt);
                    state    <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (meet) begin
                        steps_q    <= step_cnt;
`ifdef GNR_ATTRACTOR_STATE_EN
                        meet_state <= hare_vec;
`endif
                        state      <= ST_PSTEP;
                    end else if (chk_to) begin
                        state <= ST_REPORT;
                    end else begin
                        state <= ST_STEP;
                    end
                end
                ST_PSTEP: begin
                    per_cnt <= sat_inc(per_cnt);
                    state   <= ST_PCHECK;
                end
                ST_PCHECK: begin
                    if (vec_eq || per_to) state <= ST_REPORT;
                    else                  state <= ST_PSTEP;
                end
                ST_REPORT: begin
                    if (fire) begin
                        idx <= idx_nxt;
                        if (idx_nxt == n_states) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            init_vec <= base ^ N_NODES'(idx_nxt);
                            state    <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    gnr_result_reg #(.W($bits(res_rec_t))) u_res (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld_en),
        .ld_data (ld_rec),
        .valid   (res_valid),
        .ready   (res_ready),
        .data    (out_rec)
    );

    assign res_idx     = out_rec.idx;
    assign res_steps   = out_rec.steps;
    assign res_period  = out_rec.period;
    assign res_timeout = out_rec.timeout;
`ifdef GNR_ATTRACTOR_STATE_EN
    assign res_state   = out_rec.state;
`endif

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl with a 4-node behavioural network (identity or rotate).
module tb_gnr_attractor_ctrl;

    localparam int N  = 4;
    localparam int CW = 32;
`ifdef GNR_ATTRACTOR_STATE_EN
    localparam int RW = 3*CW + 1 + N;
`else
    localparam int RW = 3*CW + 1;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start;
    logic [N-1:0]  init_base;
    logic [CW-1:0] num_states, max_steps;
    logic          reset_nos, start_s0, start_s1;
    logic [N-1:0]  init_vec, tort_vec, hare_vec;
    logic          res_valid, res_ready, res_timeout, busy, done;
    logic [CW-1:0] res_idx, res_steps, res_period;
    logic [2:0]    dbg_state;
`ifdef GNR_ATTRACTOR_STATE_EN
    logic [N-1:0]  res_state;
`endif

    gnr_attractor_ctrl #(.N_NODES(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .init_base(init_base),
        .num_states(num_states), .max_steps(max_steps),
        .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1),
        .init_vec(init_vec), .tort_vec(tort_vec), .hare_vec(hare_vec),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
        .res_steps(res_steps), .res_period(res_period), .res_timeout(res_timeout),
`ifdef GNR_ATTRACTOR_STATE_EN
        .res_state(res_state),
`endif
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // behavioural node array: hare steps every strobe, tortoise on odd steps only
    int           net_rot = 0;
    logic [N-1:0] tort = '0, hare = '0;
    logic         s0_phase = 1'b0;

    function automatic logic [N-1:0] nf(input logic [N-1:0] s);
        return (net_rot != 0) ? {s[N-2:0], s[N-1]} : s;
    endfunction

    always @(posedge clk) begin
        if (reset_nos) begin
            tort     <= init_vec;
            hare     <= init_vec;
            s0_phase <= 1'b0;
        end else begin
            if (start_s1) hare <= nf(hare);
            if (start_s0) begin
                if (!s0_phase) tort <= nf(tort);
                s0_phase <= ~s0_phase;
            end
        end
    end
    assign tort_vec = tort;
    assign hare_vec = hare;

    // scoreboard
    int tests = 0, fails = 0;
    logic [RW-1:0] exp_q[$];
    logic [N-1:0]  init_q[$];
    int done_cnt = 0, rnos_cnt = 0, pstep_cnt = 0, valid_cnt = 0, stall_strobe_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk(input int idx, input int steps, input int period,
                                         input bit to, input logic [N-1:0] st);
`ifdef GNR_ATTRACTOR_STATE_EN
        return {CW'(idx), CW'(steps), CW'(period), to, st};
`else
        return {CW'(idx), CW'(steps), CW'(period), to} | RW'(st & 4'b0);
`endif
    endfunction

    logic [RW-1:0] act_rec;
`ifdef GNR_ATTRACTOR_STATE_EN
    assign act_rec = {res_idx, res_steps, res_period, res_timeout, res_state};
`else
    assign act_rec = {res_idx, res_steps, res_period, res_timeout};
`endif

    // monitor
    logic          prev_stall = 1'b0;
    logic [RW-1:0] prev_rec = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (start_s1 && !start_s0) pstep_cnt++;
            if (res_valid) valid_cnt++;
            if (res_valid && (reset_nos || start_s0 || start_s1)) stall_strobe_cnt++;
            if (reset_nos) begin
                rnos_cnt++;
                if (init_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL init_unexpected: got load of %0h expected none", init_vec);
                end else check("init_vec", init_vec, init_q.pop_front());
            end
            if (prev_stall) begin
                check("stall_valid", res_valid, 1);
                check("stall_fields", act_rec, prev_rec);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL result_unexpected: got %0h expected none", act_rec);
                end else check("result", act_rec, exp_q.pop_front());
            end
            prev_stall = res_valid && !res_ready;
            prev_rec   = act_rec;
        end
    end

    // driver tasks
    task automatic campaign(input int rot, input logic [N-1:0] b, input int n, input int ms);
        @(posedge clk); #1;
        net_rot = rot; init_base = b; num_states = CW'(n); max_steps = CW'(ms); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // scrambled after start; the controller must ignore these
        init_base = ~b; num_states = CW'(n + 5); max_steps = CW'(1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check(name, (done_cnt != d0), 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic end_checks(input string name, input int r0, input int d0, input int exp_r);
        check({name, "_loads"}, rnos_cnt - r0, exp_r);
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_results_left"}, exp_q.size(), 0);
        check({name, "_inits_left"}, init_q.size(), 0);
    endtask

    initial begin
        int r0, d0, p0, v0;
        bit found;
        rst = 1'b1; start = 1'b0; init_base = '0; num_states = '0; max_steps = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {reset_nos, start_s0, start_s1, res_valid, res_idx, res_steps,
                                res_period, res_timeout, busy, done, init_vec, dbg_state}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // identity network, one state
        r0 = rnos_cnt; d0 = done_cnt;
        exp_q.push_back(mk(0, 2, 1, 0, 4'b0101));
        init_q.push_back(4'b0101);
        campaign(0, 4'b0101, 1, 0);
        wait_done("ident_done", 200);
        end_checks("ident", r0, d0, 1);

        // rotate network, one state
        r0 = rnos_cnt; d0 = done_cnt;
        exp_q.push_back(mk(0, 8, 4, 0, 4'b0001));
        init_q.push_back(4'b0001);
        campaign(1, 4'b0001, 1, 0);
        wait_done("rot_done", 200);
        end_checks("rot", r0, d0, 1);

        // rotate network, budget 6 -> timeout before any period step
        r0 = rnos_cnt; d0 = done_cnt; p0 = pstep_cnt;
        exp_q.push_back(mk(0, 6, 0, 1, 4'b0000));
        init_q.push_back(4'b0001);
        campaign(1, 4'b0001, 1, 6);
        wait_done("tmo_done", 200);
        end_checks("tmo", r0, d0, 1);
        check("tmo_psteps", pstep_cnt - p0, 0);

        // identity, three states, first result stalled 10 cycles
        r0 = rnos_cnt; d0 = done_cnt;
        exp_q.push_back(mk(0, 2, 1, 0, 4'b0101));
        exp_q.push_back(mk(1, 2, 1, 0, 4'b0100));
        exp_q.push_back(mk(2, 2, 1, 0, 4'b0111));
        init_q.push_back(4'b0101); init_q.push_back(4'b0100); init_q.push_back(4'b0111);
        res_ready = 1'b0;
        campaign(0, 4'b0101, 3, 0);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (res_valid) found = 1'b1;
        end
        check("stall_reached", found, 1);
        repeat (10) @(posedge clk);
        #1 res_ready = 1'b1;
        wait_done("multi_done", 300);
        end_checks("multi", r0, d0, 3);

        // zero states: done the cycle after start, nothing else
        r0 = rnos_cnt; d0 = done_cnt; v0 = valid_cnt; p0 = pstep_cnt;
        campaign(0, 4'b0101, 0, 0);
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        repeat (6) @(negedge clk);
        check("zero_done_pulses", done_cnt - d0, 1);
        check("zero_loads", rnos_cnt - r0, 0);
        check("zero_valid", valid_cnt - v0, 0);
        check("zero_psteps", pstep_cnt - p0, 0);

        // reset in the middle of the period phase, then a clean restart
        init_q.push_back(4'b0011);
        campaign(0, 4'b0011, 1, 0);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (start_s1 && !start_s0) found = 1'b1;
        end
        check("abort_reached_pstep", found, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", {reset_nos, start_s0, start_s1, res_valid, res_idx, res_steps,
                                res_period, res_timeout, busy, done, init_vec, dbg_state}, 0);
        @(posedge clk); #1 rst = 1'b0;
        r0 = rnos_cnt; d0 = done_cnt;
        exp_q.push_back(mk(0, 2, 1, 0, 4'b0011));
        exp_q.push_back(mk(1, 2, 1, 0, 4'b0010));
        init_q.push_back(4'b0011); init_q.push_back(4'b0010);
        campaign(0, 4'b0011, 2, 0);
        wait_done("restart_done", 300);
        end_checks("restart", r0, d0, 2);

        check("no_strobe_while_valid", stall_strobe_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
